// File: rtl/ptr_ram_pkg.sv
// ptr_ram_pkg: command and state types shared by the ptr_ram block.
package ptr_ram_pkg;
   typedef enum logic [1:0] {
      PTR_RAM_LOAD_PTR = 2'd0,
      PTR_RAM_READ     = 2'd1,
      PTR_RAM_WRITE    = 2'd2
   } ptr_ram_op_t;
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_FETCH = 2'd1,
      RD_DATA  = 2'd2,
      WR       = 2'd3
   } ptr_ram_state_t;
endpackage

// File: rtl/ptr_ram_mem.sv
// ptr_ram_mem: one write port, one registered read port; the array itself is never reset.
module ptr_ram_mem #(
   parameter int DEPTH     = 32,
   parameter int WIDTH     = 8,
   parameter int ADDR_BITS = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] waddr,
   input  logic [WIDTH-1:0]     wdata,
   input  logic                 re,
   input  logic [ADDR_BITS-1:0] raddr,
   output logic [WIDTH-1:0]     rdata
);
   logic [WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   always_ff @(posedge clk or negedge rst)
      if (!rst) rdata <= '0;
      else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/ptr_ram.sv
// ptr_ram: pointer-addressed RAM with burst read/write commands and a wrapping pointer.
// Define PTR_RAM_PARITY_EN to store an even-parity bit per word and report it on rd_err.
module ptr_ram
   import ptr_ram_pkg::*;
#(
   parameter int DEPTH     = 32,
   parameter int DATA_BITS = 8,
   localparam int ADDR_BITS = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  ptr_ram_op_t          cmd_op,
   input  logic [ADDR_BITS-1:0] cmd_addr,
   input  logic [ADDR_BITS-1:0] cmd_len,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [DATA_BITS-1:0] wr_data,
   output logic                 rd_valid,
   input  logic                 rd_ready,
   output logic [DATA_BITS-1:0] rd_data,
   output logic [ADDR_BITS-1:0] ptr,
   output logic                 busy
`ifdef PTR_RAM_PARITY_EN
   ,
   output logic                 rd_err
`endif
);
   localparam logic [ADDR_BITS-1:0] LAST    = ADDR_BITS'(DEPTH - 1);
   localparam logic [ADDR_BITS:0]   DEPTH_W = (ADDR_BITS + 1)'(DEPTH);
`ifdef PTR_RAM_PARITY_EN
   localparam int WIDTH = DATA_BITS + 1;
`else
   localparam int WIDTH = DATA_BITS;
`endif
   ptr_ram_state_t state, state_nxt;
   logic [ADDR_BITS-1:0] remaining, rem_nxt, ptr_nxt, ptr_inc;
   logic cmd_fire, beat, last;
   logic [WIDTH-1:0] wdata, rdata;
   assign cmd_ready = state == IDLE;
   assign busy      = state != IDLE;
   assign wr_ready  = state == WR;
   assign rd_valid  = state == RD_DATA;
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign beat      = (wr_ready && wr_valid) || (rd_valid && rd_ready);
   assign last      = remaining == '0;
   // Explicit wrap so non-power-of-two depths never leave the array.
   assign ptr_inc   = (ptr == LAST) ? '0 : ptr + 1'b1;
   always_comb begin
      ptr_nxt = beat ? ptr_inc
              : (cmd_fire && cmd_op == PTR_RAM_LOAD_PTR && {1'b0, cmd_addr} < DEPTH_W) ? cmd_addr
              : ptr;
      rem_nxt = (cmd_fire && (cmd_op == PTR_RAM_READ || cmd_op == PTR_RAM_WRITE)) ? cmd_len
              : (beat && !last) ? remaining - 1'b1
              : remaining;
      state_nxt = state;
      case (state)
         IDLE:     state_nxt = !cmd_fire ? IDLE
                             : (cmd_op == PTR_RAM_READ) ? RD_FETCH
                             : (cmd_op == PTR_RAM_WRITE) ? WR : IDLE;
         RD_FETCH: state_nxt = RD_DATA;
         RD_DATA:  state_nxt = !beat ? RD_DATA : last ? IDLE : RD_FETCH;
         WR:       state_nxt = !beat ? WR : last ? IDLE : WR;
         default:  state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         ptr       <= '0;
         remaining <= '0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         remaining <= rem_nxt;
      end
   end
`ifdef PTR_RAM_PARITY_EN
   assign wdata   = {^wr_data, wr_data};
   assign rd_data = rdata[DATA_BITS-1:0];
   assign rd_err  = rd_valid && ^rdata;
`else
   assign wdata   = wr_data;
   assign rd_data = rdata;
`endif
   // rdata only changes on the fetch cycle, so rd_data holds between beats.
   ptr_ram_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_ready && wr_valid),
      .waddr (ptr),
      .wdata (wdata),
      .re    (state == RD_FETCH),
      .raddr (ptr),
      .rdata (rdata)
   );
endmodule

// File: tb/tb_ptr_ram.sv
// tb_ptr_ram: drives a DEPTH=32 and a DEPTH=20 ptr_ram in lockstep against scoreboard models.
// Define PTR_RAM_PARITY_EN to also exercise the parity-error path.
module tb_ptr_ram;
   import ptr_ram_pkg::*;
   logic clk = 0, rst = 0;
   always #5 clk = ~clk;
   logic cmd_valid = 0, wr_valid = 0, rd_ready = 0;
   ptr_ram_op_t cmd_op = PTR_RAM_LOAD_PTR;
   logic [4:0] cmd_addr = '0, cmd_len = '0;
   logic [7:0] wr_data = '0;
   logic a_cmd_ready, a_wr_ready, a_rd_valid, a_busy, b_cmd_ready, b_wr_ready, b_rd_valid, b_busy;
   logic [7:0] a_rd_data, b_rd_data;
   logic [4:0] a_ptr, b_ptr;
`ifdef PTR_RAM_PARITY_EN
   logic a_rd_err, b_rd_err;
`endif
   ptr_ram #(.DEPTH(32)) u_a (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid), .wr_ready(a_wr_ready),
      .wr_data(wr_data), .rd_valid(a_rd_valid), .rd_ready(rd_ready), .rd_data(a_rd_data),
      .ptr(a_ptr), .busy(a_busy)
`ifdef PTR_RAM_PARITY_EN
      , .rd_err(a_rd_err)
`endif
   );
   ptr_ram #(.DEPTH(20)) u_b (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid), .wr_ready(b_wr_ready),
      .wr_data(wr_data), .rd_valid(b_rd_valid), .rd_ready(rd_ready), .rd_data(b_rd_data),
      .ptr(b_ptr), .busy(b_busy)
`ifdef PTR_RAM_PARITY_EN
      , .rd_err(b_rd_err)
`endif
   );
   int vectors = 0, miscompares = 0;
   logic [7:0] ma [32];
   logic [7:0] mb [20];
   int pa = 0, pb = 0, bad = -1;
   logic [7:0] qa [$];
   logic [7:0] qb [$];
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic cmd(input ptr_ram_op_t op, input int addr, input int len);
      int n = 0;
      while (!(a_cmd_ready && b_cmd_ready) && n < 50) begin
         tick;
         n++;
      end
      check("cmd_ready", {a_cmd_ready, b_cmd_ready}, 2'b11);
      cmd_valid = 1;
      cmd_op = op;
      cmd_addr = 5'(addr);
      cmd_len = 5'(len);
      tick;
      cmd_valid = 0;
      if (op == PTR_RAM_LOAD_PTR) begin
         if (addr < 32) pa = addr;
         if (addr < 20) pb = addr;
      end
   endtask
   task automatic write(input int addr, input int len, input logic [7:0] d [$], input int gap);
      cmd(PTR_RAM_LOAD_PTR, addr, 0);
      cmd(PTR_RAM_WRITE, 0, len);
      for (int i = 0; i <= len; i++) begin
         if (gap > 0 && i > 0) begin
            repeat (gap) tick;
            check("gap_ptr_a", a_ptr, pa);
            check("gap_ptr_b", b_ptr, pb);
            check("gap_busy", a_busy, 1);
         end
         check("wr_ready", {a_wr_ready, b_wr_ready}, 2'b11);
         wr_valid = 1;
         wr_data = d[i];
         tick;
         wr_valid = 0;
         ma[pa] = d[i];
         mb[pb] = d[i];
         pa = (pa + 1) % 32;
         pb = (pb + 1) % 20;
      end
      check("wr_ptr_a", a_ptr, pa);
      check("wr_ptr_b", b_ptr, pb);
      check("wr_done_busy", {a_busy, b_busy, a_wr_ready}, 3'b000);
   endtask
   task automatic read(input int addr, input int len, input int stall_beat, input int stall);
      cmd(PTR_RAM_LOAD_PTR, addr, 0);
      for (int i = 0; i <= len; i++) begin
         qa.push_back(ma[(addr + i) % 32]);
         qb.push_back(mb[(addr + i) % 20]);
      end
      cmd(PTR_RAM_READ, 0, len);
      for (int i = 0; i <= len; i++) begin
         int n = 0;
         while (!a_rd_valid && n < 20) begin
            tick;
            n++;
         end
         check("rd_valid", {a_rd_valid, b_rd_valid}, 2'b11);
         if (i == stall_beat) begin
            repeat (stall) tick;
            check("stall_valid", a_rd_valid, 1);
            check("stall_data", a_rd_data, qa[0]);
            check("stall_ptr", a_ptr, pa);
         end
`ifdef PTR_RAM_PARITY_EN
         check("rd_err_a", a_rd_err, 32'(pa == bad));
         check("rd_err_b", b_rd_err, 32'(pb == bad));
`endif
         check("rd_data_a", a_rd_data, qa.pop_front());
         check("rd_data_b", b_rd_data, qb.pop_front());
         rd_ready = 1;
         tick;
         rd_ready = 0;
         pa = (pa + 1) % 32;
         pb = (pb + 1) % 20;
      end
      check("rd_idle", {a_rd_valid, a_busy}, 2'b00);
      check("rd_ptr_a", a_ptr, pa);
      check("rd_ptr_b", b_ptr, pb);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      logic [7:0] fill [$];
      #12;
      check("rst_ptr", {a_ptr, b_ptr}, 10'h0);
      check("rst_flags", {a_busy, a_rd_valid, a_wr_ready, b_busy}, 4'b0000);
      check("rst_rd_data", a_rd_data, 8'h00);
      @(posedge clk);
      #1;
      rst = 1;
      tick;
      check("cmd_ready_rst", a_cmd_ready, 1);
      for (int i = 0; i < 32; i++) fill.push_back(8'(i * 7 + 1));
      write(0, 31, fill, 0);
      check("fill_wrap_b", b_ptr, 12);
      read(0, 31, -1, 0);
      write(3, 3, '{8'hA0, 8'hA1, 8'hA2, 8'hA3}, 0);
      read(3, 3, -1, 0);
      check("ptr_after_burst", a_ptr, 7);
      write(18, 3, '{8'd11, 8'd22, 8'd33, 8'd44}, 0);
      check("d20_wrap_ptr", b_ptr, 2);
      read(18, 3, -1, 0);
      read(3, 3, 2, 5);
      write(8, 2, '{8'h55, 8'h66, 8'h77}, 3);
      cmd(PTR_RAM_LOAD_PTR, 25, 0);
      check("load_oob_b", b_ptr, 11);
      check("load_ok_a", a_ptr, 25);
      read(8, 2, -1, 0);
      write(10, 3, '{8'hC0, 8'hC1, 8'hC2, 8'hC3}, 0);
      cmd(PTR_RAM_LOAD_PTR, 10, 0);
      cmd(PTR_RAM_WRITE, 0, 3);
      for (int i = 0; i < 2; i++) begin
         wr_valid = 1;
         wr_data = 8'hD0 + 8'(i);
         tick;
         wr_valid = 0;
         ma[pa] = wr_data;
         mb[pb] = wr_data;
         pa++;
         pb++;
      end
      rst = 0;
      #1;
      check("mid_rst_busy", {a_busy, b_busy, a_wr_ready, a_rd_valid}, 4'b0000);
      check("mid_rst_ptr", a_ptr, 0);
      pa = 0;
      pb = 0;
      tick;
      rst = 1;
      tick;
      check("mid_rst_rd_data", a_rd_data, 8'h00);
      read(10, 3, -1, 0);
`ifdef PTR_RAM_PARITY_EN
      u_a.u_mem.mem[5][0] = ~u_a.u_mem.mem[5][0];
      u_b.u_mem.mem[5][0] = ~u_b.u_mem.mem[5][0];
      ma[5][0] = ~ma[5][0];
      mb[5][0] = ~mb[5][0];
      bad = 5;
      read(4, 2, -1, 0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
